if_id_skid_stage: RTL and testbench
===================================

# if_id_skid_stage

Parametrised IF/ID pipeline stage with valid/ready handshaking, an optional two-entry skid buffer, synchronous flush with NOP injection, and asynchronous reset. It sits between instruction fetch and decode. It replaces the plain enable-gated IF/ID register so that decode back-pressure and branch flushes are handled inside the stage without losing or duplicating fetched instructions.

## Interface
- DATA_LENGTH, 32, instruction width
- PC_WIDTH, 32, width of pc and pc_plus4
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- NOP_INSN, 32'h0000_0013, instruction presented when the stage holds no valid entry (addi x0,x0,0)

- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  stage can accept an entry
- ins_in  in  DATA_LENGTH  fetched instruction
- pc_in  in  PC_WIDTH  pc of the instruction
- pc_plus4_in  in  PC_WIDTH  pc + 4
- flush  in  1  synchronous kill of all held and incoming entries
- out_valid  out  1  decode entry valid
- out_ready  in  1  decode consumes the entry
- ins_out  out  DATA_LENGTH  instruction to decode; NOP_INSN when out_valid=0
- pc_out  out  PC_WIDTH  pc to decode; 0 when out_valid=0
- pc_plus4_out  out  PC_WIDTH  pc+4 to decode; 0 when out_valid=0

## Operation
- Entry = {ins, pc, pc_plus4}.
- Input handshake: an entry is accepted on a cycle with in_valid && in_ready. Output handshake: an entry is consumed on a cycle with out_valid && out_ready.
- Reset (async assert, held until deassert):
  - out_valid=0, ins_out=NOP_INSN, pc_out=0, pc_plus4_out=0.
  - Skid entry invalid.
  - in_ready=1.
- Main register: drives the outputs.
- SKID_EN=1:
  - in_ready = !skid_valid, registered.
  - Main empty or being consumed: the main register loads from the skid entry if it is valid, otherwise from an accepted input.
  - Main full, not consumed, and an input is accepted: the input goes to the skid entry.
  - Skid valid and main consumed, with no new accept possible: the skid entry moves to main and the skid entry clears.
- SKID_EN=0:
  - in_ready = !out_valid || out_ready.
  - An accepted input loads main.
  - Consumed with no accept: out_valid=0 and the NOP/0 values are loaded.
- Whenever out_valid falls, the main payload is loaded with NOP_INSN/0/0.
- flush has priority over all handshakes:
  - Next cycle: out_valid=0, skid invalid, outputs NOP_INSN/0/0.
  - An entry accepted in the flush cycle is discarded. Upstream treats it as taken.
  - A consume in the flush cycle still completes. Decode owns that entry.
- Order is preserved: no entry is lost, duplicated or reordered outside of a flush.

## Timing
- Latency: input accept at edge N gives out_valid=1 after edge N, when the stage was empty.
- Throughput: 1 entry/cycle with out_ready held at 1, in both modes.
- SKID_EN=1: in_ready falls one cycle after the skid entry fills. The skid entry absorbs the in-flight entry, so no combinational path from out_ready to in_ready.
- SKID_EN=0: combinational path from out_ready to in_ready.
- Occupancy boundaries:
  - Empty: out_valid=0.
  - Full (SKID_EN=1): main and skid both valid, in_ready=0.
  - Simultaneous accept and consume when full: skid→main, input accepted into skid. This case only arises on the edge where in_ready was 1.
- Reset asserted mid-transfer clears everything immediately. No entry survives.

## Structure
- Package pipe_pkg:
  - NOP_INSN default constant.
  - if_id_entry_t packed struct {ins, pc, pc_plus4}, parameterised through localparam widths.
- Sub-module pipe_skid_buf: generic WIDTH payload with valid/ready, flush, and SKID_EN.
- if_id_skid_stage: packs and unpacks if_id_entry_t, and applies the NOP/0 substitution.

## Test plan
- Reset: assert rst mid-cycle with both entries full → outputs immediately 0/NOP_INSN(0x00000013)/0/0 and in_ready=1.
- Streaming: out_ready=1, feed pc=0x0,0x4,0x8,… with ins=pc+0x100 → each appears one cycle later, 1/cycle, no gaps.
- Back-pressure (SKID_EN=1): drop out_ready for 3 cycles while in_valid=1 → exactly two entries held, in_ready=0 from the cycle after the skid fills; release → entries emerge in order, none lost or duplicated.
- Flush: flush with main=pc 0x10 and skid=pc 0x14, while pc 0x18 is accepted → next cycle out_valid=0 and NOP; pc 0x1C, fed after the flush, is the next entry out.
- Random valid/ready (both SKID_EN values, 10k cycles) with scoreboard → output sequence equals input sequence minus flushed entries; no X on outputs.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the fetch/decode pipeline stage.
//   INSN_W / PC_W    : default instruction and pc widths
//   NOP_INSN_DEFAULT : instruction shown to decode when the stage is empty
//                      (addi x0,x0,0)
//   if_id_entry_t    : one fetched entry {ins, pc, pc_plus4} at the default widths
package pipe_pkg;

    localparam int INSN_W = 32;
    localparam int PC_W   = 32;

    localparam logic [INSN_W-1:0] NOP_INSN_DEFAULT = 32'h0000_0013;

    typedef struct packed {
        logic [INSN_W-1:0] ins;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pc_plus4;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_skid_stage_if.sv
// if_id_skid_stage_if
// Valid/ready bus carrying one fetched entry between pipeline stages.
//   valid    : producer presents an entry
//   ready    : consumer can take the entry
//   ins      : instruction word
//   pc       : pc of the instruction
//   pc_plus4 : pc + 4
// master = producer side (drives valid and payload), slave = consumer side
// (drives ready).
interface if_id_skid_stage_if #(
    parameter int DATA_LENGTH = 32,
    parameter int PC_WIDTH    = 32
) ();

    logic                   valid;
    logic                   ready;
    logic [DATA_LENGTH-1:0] ins;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pc_plus4;

    modport master (output valid, output ins, output pc, output pc_plus4, input ready);
    modport slave  (input valid, input ins, input pc, input pc_plus4, output ready);

endinterface

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf
// Generic valid/ready pipeline register with an optional skid entry.
//   clk, rst     : clock, asynchronous active-high reset
//   flush_i      : synchronous kill of held and incoming entries
//   in_valid_i   : upstream presents in_data_i
//   in_ready_o   : buffer accepts this cycle
//   in_data_i    : upstream payload
//   out_valid_o  : main register holds a valid payload
//   out_ready_i  : downstream consumes the main payload
//   out_data_o   : main payload, EMPTY_VAL whenever out_valid_o is low
// SKID_EN=1: main + skid entries, in_ready_o comes straight from a flop.
// SKID_EN=0: main only, in_ready_o depends combinationally on out_ready_i.
module pipe_skid_buf #(
    parameter int               WIDTH     = 8,
    parameter bit               SKID_EN   = 1'b1,
    parameter logic [WIDTH-1:0] EMPTY_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             mainValid_q, mainValid_d;
    logic [WIDTH-1:0] mainData_q, mainData_d;
    logic             skidValid_q, skidValid_d;
    logic [WIDTH-1:0] skidData_q, skidData_d;
    logic             accept;
    logic             consume;

    // With the skid entry present, ready only depends on whether the skid is
    // free, so an entry already in flight when decode stalls always has a home.
    assign in_ready_o  = SKID_EN ? !skidValid_q : (!mainValid_q || out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign consume     = mainValid_q && out_ready_i;
    assign out_valid_o = mainValid_q;
    assign out_data_o  = mainData_q;

    // Next-state selection. Flush wins over everything; the skid entry is always
    // older than any new input, so it refills main first to keep ordering.
    always_comb begin
        mainValid_d = mainValid_q;
        mainData_d  = mainData_q;
        skidValid_d = skidValid_q;
        skidData_d  = skidData_q;
        if (flush_i) begin
            mainValid_d = 1'b0;
            mainData_d  = EMPTY_VAL;
            skidValid_d = 1'b0;
        end else if (SKID_EN) begin
            if (!mainValid_q || out_ready_i) begin
                if (skidValid_q) begin
                    mainValid_d = 1'b1;
                    mainData_d  = skidData_q;
                    skidValid_d = accept;
                    if (accept) begin
                        skidData_d = in_data_i;
                    end
                end else if (accept) begin
                    mainValid_d = 1'b1;
                    mainData_d  = in_data_i;
                end else begin
                    mainValid_d = 1'b0;
                    mainData_d  = EMPTY_VAL;
                end
            end else if (accept) begin
                skidValid_d = 1'b1;
                skidData_d  = in_data_i;
            end
        end else begin
            if (accept) begin
                mainValid_d = 1'b1;
                mainData_d  = in_data_i;
            end else if (consume) begin
                mainValid_d = 1'b0;
                mainData_d  = EMPTY_VAL;
            end
        end
    end

    // State registers; reset empties both entries and parks the payload at
    // the empty value so decode sees a clean NOP immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mainValid_q <= 1'b0;
            mainData_q  <= EMPTY_VAL;
            skidValid_q <= 1'b0;
            skidData_q  <= '0;
        end else begin
            mainValid_q <= mainValid_d;
            mainData_q  <= mainData_d;
            skidValid_q <= skidValid_d;
            skidData_q  <= skidData_d;
        end
    end

endmodule

// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage
// IF/ID pipeline stage with valid/ready handshaking, optional skid entry and
// flush with NOP injection.
//   clk, rst : clock, asynchronous active-high reset
//   flush    : synchronous kill of all held and incoming entries
//   fetch    : slave side of the fetch bus (in_valid/in_ready/ins/pc/pc_plus4)
//   decode   : master side of the decode bus (out_valid/out_ready/ins/pc/pc_plus4)
// While decode.valid is low, decode presents NOP_INSN with pc/pc_plus4 = 0.
module if_id_skid_stage
    import pipe_pkg::*;
#(
    parameter int                     DATA_LENGTH = INSN_W,
    parameter int                     PC_WIDTH    = PC_W,
    parameter bit                     SKID_EN     = 1'b1,
    parameter logic [DATA_LENGTH-1:0] NOP_INSN    = DATA_LENGTH'(NOP_INSN_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    if_id_skid_stage_if.slave   fetch,
    if_id_skid_stage_if.master  decode
);

    // Same layout as pipe_pkg::if_id_entry_t, sized by this instance's widths.
    typedef struct packed {
        logic [DATA_LENGTH-1:0] ins;
        logic [PC_WIDTH-1:0]    pc;
        logic [PC_WIDTH-1:0]    pc_plus4;
    } entry_t;

    localparam int     ENTRY_W     = DATA_LENGTH + 2 * PC_WIDTH;
    localparam entry_t EMPTY_ENTRY = '{ins: NOP_INSN, pc: '0, pc_plus4: '0};

    entry_t inEntry;
    entry_t outEntry;
    logic   outValid;
    logic   inReady;

    assign inEntry = '{ins: fetch.ins, pc: fetch.pc, pc_plus4: fetch.pc_plus4};

    // The buffer loads EMPTY_ENTRY whenever main goes empty, which gives the
    // NOP/0/0 substitution without an output mux.
    pipe_skid_buf #(
        .WIDTH     (ENTRY_W),
        .SKID_EN   (SKID_EN),
        .EMPTY_VAL (EMPTY_ENTRY)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (fetch.valid),
        .in_ready_o  (inReady),
        .in_data_i   (inEntry),
        .out_valid_o (outValid),
        .out_ready_i (decode.ready),
        .out_data_o  (outEntry)
    );

    assign fetch.ready     = inReady;
    assign decode.valid    = outValid;
    assign decode.ins      = outEntry.ins;
    assign decode.pc       = outEntry.pc;
    assign decode.pc_plus4 = outEntry.pc_plus4;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb_if_id_skid_stage
// Drives a SKID_EN=1 stage (A) and a SKID_EN=0 stage (B) from the same fetch
// and decode stimulus. A scoreboard per stage records accepted entries and
// checks each consumed entry in order; directed tasks check cycle behaviour.
module tb_if_id_skid_stage;
    import pipe_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic [31:0] insIn;
    logic [31:0] pcIn;
    logic [31:0] pc4In;
    logic        outReady;

    int checks   = 0;
    int failures = 0;

    if_id_entry_t sbA[$];
    if_id_entry_t sbB[$];
    if_id_entry_t gotA, expA, gotB, expB;

    if_id_skid_stage_if #(.DATA_LENGTH(32), .PC_WIDTH(32)) fetchA ();
    if_id_skid_stage_if #(.DATA_LENGTH(32), .PC_WIDTH(32)) decA ();
    if_id_skid_stage_if #(.DATA_LENGTH(32), .PC_WIDTH(32)) fetchB ();
    if_id_skid_stage_if #(.DATA_LENGTH(32), .PC_WIDTH(32)) decB ();

    assign fetchA.valid    = inValid;
    assign fetchA.ins      = insIn;
    assign fetchA.pc       = pcIn;
    assign fetchA.pc_plus4 = pc4In;
    assign decA.ready      = outReady;
    assign fetchB.valid    = inValid;
    assign fetchB.ins      = insIn;
    assign fetchB.pc       = pcIn;
    assign fetchB.pc_plus4 = pc4In;
    assign decB.ready      = outReady;

    if_id_skid_stage #(.DATA_LENGTH(32), .PC_WIDTH(32), .SKID_EN(1'b1), .NOP_INSN(32'h0000_0013)) dutA (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .fetch  (fetchA),
        .decode (decA)
    );

    if_id_skid_stage #(.DATA_LENGTH(32), .PC_WIDTH(32), .SKID_EN(1'b0), .NOP_INSN(32'h0000_0013)) dutB (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .fetch  (fetchB),
        .decode (decB)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor, sampled on the falling edge so inputs and outputs are
    // settled. Consumes are checked before accepts are recorded; a flush drops
    // everything held plus the entry accepted in the same cycle.
    always @(negedge clk) begin
        if (rst) begin
            sbA.delete();
            sbB.delete();
        end else begin
            checks++;
            if ($isunknown({decA.valid, decA.ins, decA.pc, decA.pc_plus4, fetchA.ready})) begin
                failures++;
                $display("[TB] FAIL xcheck_A got=%b_%h_%h_%h_%b", decA.valid, decA.ins, decA.pc, decA.pc_plus4, fetchA.ready);
            end
            checks++;
            if ($isunknown({decB.valid, decB.ins, decB.pc, decB.pc_plus4, fetchB.ready})) begin
                failures++;
                $display("[TB] FAIL xcheck_B got=%b_%h_%h_%h_%b", decB.valid, decB.ins, decB.pc, decB.pc_plus4, fetchB.ready);
            end
            if (!decA.valid) begin
                checks++;
                if ({decA.ins, decA.pc, decA.pc_plus4} !== {NOP, 32'h0, 32'h0}) begin
                    failures++;
                    $display("[TB] FAIL idle_nop_A got=%h_%h_%h exp=%h_0_0", decA.ins, decA.pc, decA.pc_plus4, NOP);
                end
            end
            if (!decB.valid) begin
                checks++;
                if ({decB.ins, decB.pc, decB.pc_plus4} !== {NOP, 32'h0, 32'h0}) begin
                    failures++;
                    $display("[TB] FAIL idle_nop_B got=%h_%h_%h exp=%h_0_0", decB.ins, decB.pc, decB.pc_plus4, NOP);
                end
            end
            if (decA.valid && outReady) begin
                checks++;
                gotA = '{ins: decA.ins, pc: decA.pc, pc_plus4: decA.pc_plus4};
                if (sbA.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL sb_A_unexpected got=%h exp=<none>", gotA);
                end else begin
                    expA = sbA.pop_front();
                    if (gotA !== expA) begin
                        failures++;
                        $display("[TB] FAIL sb_A_order got=%h exp=%h", gotA, expA);
                    end
                end
            end
            if (decB.valid && outReady) begin
                checks++;
                gotB = '{ins: decB.ins, pc: decB.pc, pc_plus4: decB.pc_plus4};
                if (sbB.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL sb_B_unexpected got=%h exp=<none>", gotB);
                end else begin
                    expB = sbB.pop_front();
                    if (gotB !== expB) begin
                        failures++;
                        $display("[TB] FAIL sb_B_order got=%h exp=%h", gotB, expB);
                    end
                end
            end
            if (flush) begin
                sbA.delete();
                sbB.delete();
            end else begin
                if (inValid && fetchA.ready) sbA.push_back('{ins: insIn, pc: pcIn, pc_plus4: pc4In});
                if (inValid && fetchB.ready) sbB.push_back('{ins: insIn, pc: pcIn, pc_plus4: pc4In});
            end
        end
    end

    // Present an entry derived from its pc (ins = pc + 0x100).
    task automatic present(input logic v, input logic [31:0] pc);
        inValid = v;
        pcIn    = pc;
        insIn   = pc + 32'h100;
        pc4In   = pc + 32'h4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle both stages with decode ready until they have drained.
    task automatic drain();
        present(1'b0, 32'h0);
        flush    = 1'b0;
        outReady = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        present(1'b0, 32'h0);
        flush    = 1'b0;
        outReady = 1'b0;
        repeat (2) step();
        checks++;
        if ({decA.valid, decA.ins, decA.pc, decA.pc_plus4, fetchA.ready} !== {1'b0, NOP, 32'h0, 32'h0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL reset_A got=%h exp=%h", {decA.valid, decA.ins, decA.pc, decA.pc_plus4, fetchA.ready}, {1'b0, NOP, 64'h0, 1'b1});
        end
        checks++;
        if ({decB.valid, decB.ins, decB.pc, decB.pc_plus4} !== {1'b0, NOP, 32'h0, 32'h0}) begin
            failures++;
            $display("[TB] FAIL reset_B got=%h exp=%h", {decB.valid, decB.ins, decB.pc, decB.pc_plus4}, {1'b0, NOP, 64'h0});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_streaming();
        logic [31:0] pc;
        outReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pc = 32'(k * 4);
            present(1'b1, pc);
            step();
            checks++;
            if ({decA.valid, decA.ins, decA.pc, decA.pc_plus4} !== {1'b1, pc + 32'h100, pc, pc + 32'h4}) begin
                failures++;
                $display("[TB] FAIL stream_A[%0d] got=%b_%h_%h exp=1_%h_%h", k, decA.valid, decA.ins, decA.pc, pc + 32'h100, pc);
            end
            checks++;
            if ({decB.valid, decB.ins, decB.pc, decB.pc_plus4} !== {1'b1, pc + 32'h100, pc, pc + 32'h4}) begin
                failures++;
                $display("[TB] FAIL stream_B[%0d] got=%b_%h_%h exp=1_%h_%h", k, decB.valid, decB.ins, decB.pc, pc + 32'h100, pc);
            end
        end
        present(1'b0, 32'h0);
        step();
        checks++;
        if ({decA.valid, decB.valid} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL stream_empty got=%b exp=00", {decA.valid, decB.valid});
        end
        drain();
    endtask

    // Stage A: decode stalls for three edges while fetch keeps offering entries.
    task automatic test_back_pressure();
        logic        rdyTab[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        expVal[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int          expIdx[7] = '{0, 0, 0, 1, 2, 3, 0};
        logic        expRdy[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int          idx = 0;
        logic        acc;
        logic [31:0] epc;
        for (int k = 0; k < 7; k++) begin
            outReady = rdyTab[k];
            present(idx < 4, 32'h40 + 32'(idx * 4));
            @(negedge clk);
            acc = inValid && fetchA.ready;
            step();
            if (acc) idx++;
            epc = 32'h40 + 32'(expIdx[k] * 4);
            checks++;
            if (expVal[k]) begin
                if ({decA.valid, decA.pc, decA.ins, fetchA.ready} !== {1'b1, epc, epc + 32'h100, expRdy[k]}) begin
                    failures++;
                    $display("[TB] FAIL backpressure[%0d] got=%b_%h_%h_%b exp=1_%h_%h_%b", k, decA.valid, decA.pc, decA.ins, fetchA.ready, epc, epc + 32'h100, expRdy[k]);
                end
            end else if ({decA.valid, fetchA.ready} !== {1'b0, expRdy[k]}) begin
                failures++;
                $display("[TB] FAIL backpressure[%0d] got=%b_%b exp=0_%b", k, decA.valid, fetchA.ready, expRdy[k]);
            end
        end
        drain();
    endtask

    task automatic test_flush();
        outReady = 1'b0;
        present(1'b1, 32'h10);
        step();
        present(1'b1, 32'h14);
        step();
        checks++;
        if ({decA.valid, decA.pc, fetchA.ready} !== {1'b1, 32'h10, 1'b0}) begin
            failures++;
            $display("[TB] FAIL flush_full_A got=%b_%h_%b exp=1_00000010_0", decA.valid, decA.pc, fetchA.ready);
        end
        present(1'b1, 32'h18);
        outReady = 1'b1;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if ({decA.valid, decA.ins, decA.pc, decA.pc_plus4, fetchA.ready} !== {1'b0, NOP, 32'h0, 32'h0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL flush_kill_A got=%b_%h_%h_%h_%b exp=0_%h_0_0_1", decA.valid, decA.ins, decA.pc, decA.pc_plus4, fetchA.ready, NOP);
        end
        checks++;
        if ({decB.valid, decB.ins, decB.pc, decB.pc_plus4} !== {1'b0, NOP, 32'h0, 32'h0}) begin
            failures++;
            $display("[TB] FAIL flush_kill_B got=%b_%h_%h_%h exp=0_%h_0_0", decB.valid, decB.ins, decB.pc, decB.pc_plus4, NOP);
        end
        present(1'b1, 32'h1C);
        step();
        checks++;
        if ({decA.valid, decA.pc, decB.valid, decB.pc} !== {1'b1, 32'h1C, 1'b1, 32'h1C}) begin
            failures++;
            $display("[TB] FAIL flush_next got=%b_%h_%b_%h exp=1_0000001c_1_0000001c", decA.valid, decA.pc, decB.valid, decB.pc);
        end
        drain();
    endtask

    // Fill stage A, then assert reset between clock edges.
    task automatic test_reset_midcycle();
        outReady = 1'b0;
        present(1'b1, 32'h200);
        step();
        present(1'b1, 32'h204);
        step();
        checks++;
        if ({decA.valid, fetchA.ready} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL midreset_fill got=%b exp=10", {decA.valid, fetchA.ready});
        end
        #2;
        rst = 1'b1;
        present(1'b0, 32'h0);
        #1;
        checks++;
        if ({decA.valid, decA.ins, decA.pc, decA.pc_plus4, fetchA.ready} !== {1'b0, NOP, 32'h0, 32'h0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL midreset_A got=%b_%h_%h_%h_%b exp=0_%h_0_0_1", decA.valid, decA.ins, decA.pc, decA.pc_plus4, fetchA.ready, NOP);
        end
        checks++;
        if ({decB.valid, decB.ins, decB.pc, decB.pc_plus4} !== {1'b0, NOP, 32'h0, 32'h0}) begin
            failures++;
            $display("[TB] FAIL midreset_B got=%b_%h_%h_%h exp=0_%h_0_0", decB.valid, decB.ins, decB.pc, decB.pc_plus4, NOP);
        end
        step();
        rst = 1'b0;
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            inValid  = ($urandom_range(0, 9) < 7);
            outReady = ($urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 49) == 0);
            pcIn     = $urandom;
            insIn    = $urandom;
            pc4In    = pcIn + 32'h4;
            step();
        end
        drain();
        checks++;
        if ({sbA.size() == 0, sbB.size() == 0, decA.valid, decB.valid} !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL random_drain got=leftA:%0d leftB:%0d valid:%b%b exp=0 0 00", sbA.size(), sbB.size(), decA.valid, decB.valid);
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_reset_midcycle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
